mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the RAM unit's second (data) port between two requesters: r0 = CPU load/store, r1 = debug/loader.
//  Sequences each access to match the RAM's multi-cycle protocol: load = 1 issue + 1 avail cycle; store = read + rewrite.
//  Checks alignment, applies round-robin fairness and a load timeout, and drives a stall to the PC unit's cycle mask.
// PARAMETERS
//  TIMEOUT    8  max cycles in LD_WAIT without mem_avail before the access is aborted with error
//  ST_CYCLES  2  busy cycles the RAM spends on a store (read + rewrite)
// PORTS
//  clk         in   1   clock; all state on rising edge
//  reset       in   1   synchronous, active-high
//  rN_req      in   1   request, N=0,1; held with fields stable until rN_ack
//  rN_we       in   1   1 = store, 0 = load
//  rN_adr      in   32  byte address
//  rN_wdata    in   32  store data, in the low bits for H/B
//  rN_mode     in   2   0=word 1=half 2=byte 3=illegal
//  rN_ack      out  1   one-cycle completion pulse
//  rN_err      out  1   valid with rN_ack: misaligned, illegal mode or timeout
//  rN_rdata    out  32  load data, valid with rN_ack; 0 on error or store
//  mem_en      out  1   to RAM port2en; exactly one cycle per access
//  mem_we      out  1   to RAM port2WEn
//  mem_adr     out  32  latched address
//  mem_wdata   out  32  latched store data
//  mem_mode    out  2   latched mode
//  mem_rdata   in   32  RAM port2o
//  mem_avail   in   1   RAM port2avail
//  stall       out  1   = rN_req(any) | (state != IDLE); the core gates cycleMask with it
// BEHAVIOUR
//  Reset: state=IDLE; last_grant=1 so r0 wins the first tie; all outputs 0; latches cleared; counters 0.
//  Arbitration happens in IDLE only:
//   - One requester: grant it.
//   - Both: grant the requester that is not last_grant.
//   - last_grant updates on grant.
//  On grant, latch we, adr, wdata, mode and id.
//   - Legal access: go to ISSUE.
//   - Illegal access: go straight to DONE with err=1 and no memory access. Illegal = mode 3; mode 0 with adr[1:0]!=0; mode 1 with adr[0]=1.
//  ISSUE: mem_en=1 for one cycle with the latched fields.
//   - Load: go to LD_WAIT.
//   - Store: go to ST_WAIT with cnt=0.
//  LD_WAIT:
//   - mem_avail=1: capture mem_rdata; go to DONE.
//   - Otherwise cnt++. When cnt reaches TIMEOUT-1 with no avail: go to DONE, err=1, rdata=0.
//  ST_WAIT: cnt++; after ST_CYCLES cycles go to DONE. The RAM is back in its fetch state in the DONE cycle.
//  DONE: ack=1 and err/rdata for the latched id only, for exactly one cycle; then IDLE.
//  The other requester's ack/err/rdata are 0 at all times except its own DONE.
//  Latency from first IDLE cycle with req:
//   - Load ack at +3.
//   - Store ack at +4.
//   - Error ack at +1.
//  A requester must drop req the cycle after ack. A req still high in the next IDLE is treated as a new access and is subject to round-robin.
//  req deasserted mid-access is ignored; the access completes and is acked.
//  mem_en is never asserted outside ISSUE. mem_adr, mem_wdata, mem_mode and mem_we hold their latched values until the next grant.
//  Reset mid-access aborts to IDLE with no ack. The RAM is reset in the same cycle.
// TESTING
//  r0 load word @0x10, mem_avail at ISSUE+1 with 0xDEADBEEF -> mem_en one cycle; r0_ack at +3, rdata=0xDEADBEEF, err=0.
//  r1 store byte 0xAB @0x203 -> mem_en=1, mem_we=1, mem_mode=2, mem_adr=0x203; r1_ack at +4; no r0_ack.
//  r0 and r1 both requesting continuously after reset -> grants alternate r0,r1,r0,r1; each ack goes to the correct port.
//  r0 load half @0x11, then r0 mode=3 -> each gets ack+err at +1, mem_en never asserted.
//  r0 load with mem_avail held low -> r0_ack with err=1 and rdata=0 after TIMEOUT wait cycles; stall=1 throughout, then 0.
//  reset asserted in ST_WAIT -> next cycle IDLE, all outputs 0, no ack; a following r1 load completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the RAM data port between the CPU (r0) and the
// debug/loader (r1). Round-robin grant, alignment check, load timeout, and a
// stall to the PC unit while any request is pending or an access is in flight.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT   = 8,
   parameter int unsigned ST_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [31:0] r0_adr,
   input  logic [31:0] r0_wdata,
   input  logic [1:0]  r0_mode,
   output logic        r0_ack,
   output logic        r0_err,
   output logic [31:0] r0_rdata,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [31:0] r1_adr,
   input  logic [31:0] r1_wdata,
   input  logic [1:0]  r1_mode,
   output logic        r1_ack,
   output logic        r1_err,
   output logic [31:0] r1_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_mode,
   input  logic [31:0] mem_rdata,
   input  logic        mem_avail,
   output logic        stall
);

   localparam int unsigned CNT_W = (TIMEOUT > ST_CYCLES) ? $clog2(TIMEOUT) + 1
                                                         : $clog2(ST_CYCLES) + 1;

   typedef enum logic [2:0] {IDLE, ISSUE, LD_WAIT, ST_WAIT, DONE} stateT;

   stateT             state, stateNext;
   logic [CNT_W-1:0]  cnt, cntNext;
   logic              lastGrant, lastGrantNext;
   logic              id, idNext;
   logic              weNext;
   logic [31:0]       adrNext, wdataNext;
   logic [1:0]        modeNext;
   logic              errNext;
   logic [31:0]       rdataNext;
   logic              grantId;
   logic              selWe;
   logic [31:0]       selAdr, selWdata;
   logic [1:0]        selMode;
   logic              selIllegal;
   logic              doneNext;

   // Stall the core whenever the port is wanted or busy.
   assign stall = r0_req | r1_req | (state != IDLE);

   // Next-state, latch updates and completion status.
   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      lastGrantNext = lastGrant;
      idNext        = id;
      weNext        = mem_we;
      adrNext       = mem_adr;
      wdataNext     = mem_wdata;
      modeNext      = mem_mode;
      errNext       = 1'b0;
      rdataNext     = 32'h0;
      grantId       = (r0_req && r1_req) ? ~lastGrant : r1_req;
      selWe         = grantId ? r1_we    : r0_we;
      selAdr        = grantId ? r1_adr   : r0_adr;
      selWdata      = grantId ? r1_wdata : r0_wdata;
      selMode       = grantId ? r1_mode  : r0_mode;
      selIllegal    = (selMode == 2'd3) ||
                      ((selMode == 2'd0) && (selAdr[1:0] != 2'b00)) ||
                      ((selMode == 2'd1) && selAdr[0]);
      case (state)
         IDLE: begin
            if (r0_req || r1_req) begin
               idNext        = grantId;
               lastGrantNext = grantId;
               weNext        = selWe;
               adrNext       = selAdr;
               wdataNext     = selWdata;
               modeNext      = selMode;
               if (selIllegal) begin
                  errNext   = 1'b1;
                  stateNext = DONE;
               end else begin
                  stateNext = ISSUE;
               end
            end
         end
         ISSUE: begin
            cntNext   = '0;
            stateNext = mem_we ? ST_WAIT : LD_WAIT;
         end
         LD_WAIT: begin
            if (mem_avail) begin
               rdataNext = mem_rdata;
               stateNext = DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               errNext   = 1'b1;
               stateNext = DONE;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (cnt == CNT_W'(ST_CYCLES - 1)) begin
               stateNext = DONE;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      doneNext = (stateNext == DONE);
   end

   // State, latched access fields and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lastGrant <= 1'b1;
         id        <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_adr   <= 32'h0;
         mem_wdata <= 32'h0;
         mem_mode  <= 2'd0;
         r0_ack    <= 1'b0;
         r0_err    <= 1'b0;
         r0_rdata  <= 32'h0;
         r1_ack    <= 1'b0;
         r1_err    <= 1'b0;
         r1_rdata  <= 32'h0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         lastGrant <= lastGrantNext;
         id        <= idNext;
         mem_en    <= (stateNext == ISSUE);
         mem_we    <= weNext;
         mem_adr   <= adrNext;
         mem_wdata <= wdataNext;
         mem_mode  <= modeNext;
         r0_ack    <= doneNext && !idNext;
         r0_err    <= doneNext && !idNext && errNext;
         r0_rdata  <= (doneNext && !idNext) ? rdataNext : 32'h0;
         r1_ack    <= doneNext && idNext;
         r1_err    <= doneNext && idNext && errNext;
         r1_rdata  <= (doneNext && idNext) ? rdataNext : 32'h0;
      end
   end

endmodule
